// File: rtl/mips_mem_pkg.sv
// ---------------------------------------------------------------------------
// mips_mem_pkg
//   Shared definitions for the MEM-stage data-memory access path.
//   - MemOp encodings (also used by the decoder that drives MemOpIn)
//   - FSM state encoding for mem_access_unit
//   - Helpers that classify a MemOp as legal and naturally aligned
// ---------------------------------------------------------------------------
package mips_mem_pkg;

    localparam logic [2:0] MEMOP_LB  = 3'b000;  // byte, sign-extended
    localparam logic [2:0] MEMOP_LH  = 3'b001;  // half, sign-extended
    localparam logic [2:0] MEMOP_LW  = 3'b010;  // word
    localparam logic [2:0] MEMOP_LBU = 3'b011;  // byte, zero-extended
    localparam logic [2:0] MEMOP_LHU = 3'b100;  // half, zero-extended

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } mem_state_t;

    function automatic logic memop_legal(input logic [2:0] op);
        case (op)
            MEMOP_LB, MEMOP_LH, MEMOP_LW, MEMOP_LBU, MEMOP_LHU: return 1'b1;
            default:                                           return 1'b0;
        endcase
    endfunction

    // Halves need addr[0]=0, words need addr[1:0]=0; bytes are always aligned.
    function automatic logic memop_aligned(input logic [2:0] op, input logic [1:0] off);
        case (op)
            MEMOP_LH, MEMOP_LHU: return ~off[0];
            MEMOP_LW:            return (off == 2'b00);
            default:             return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// ---------------------------------------------------------------------------
// mem_lane_align
//   Purely combinational byte-lane steering for the data-memory bus.
//   Ports:
//     op_i     MemOp (size/sign)
//     off_i    byte offset, addr[1:0]
//     wdata_i  right-aligned store data
//     rdata_i  raw read word from memory
//     be_o     byte enables, bit i = lane i (little-endian)
//     wdata_o  store data replicated into every lane of its size
//     ldata_o  selected lane, sign/zero-extended to 32 bits
// ---------------------------------------------------------------------------
module mem_lane_align
    import mips_mem_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ldata_o
);

    function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic sgn);
        return sgn ? {{24{b[7]}}, b} : {24'h000000, b};
    endfunction

    function automatic logic [31:0] ext_half(input logic [15:0] h, input logic sgn);
        return sgn ? {{16{h[15]}}, h} : {16'h0000, h};
    endfunction

    // Read lane starting at the addressed byte; upper byte only matters for halves.
    logic [15:0] lane;

    always_comb begin
        case (off_i)
            2'd0:    lane = rdata_i[15:0];
            2'd1:    lane = rdata_i[23:8];
            2'd2:    lane = rdata_i[31:16];
            default: lane = {8'h00, rdata_i[31:24]};
        endcase
    end

    always_comb begin
        be_o    = 4'b0000;
        wdata_o = wdata_i;
        ldata_o = rdata_i;
        case (op_i)
            MEMOP_LB, MEMOP_LBU: begin
                be_o    = 4'b0001 << off_i;
                wdata_o = {4{wdata_i[7:0]}};
                ldata_o = ext_byte(lane[7:0], op_i == MEMOP_LB);
            end
            MEMOP_LH, MEMOP_LHU: begin
                be_o    = 4'b0011 << off_i;
                wdata_o = {2{wdata_i[15:0]}};
                ldata_o = ext_half(lane, op_i == MEMOP_LH);
            end
            MEMOP_LW: begin
                be_o = 4'b1111;
            end
            default: begin
                be_o = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//   MEM-stage load/store engine. Converts the EX/MEM load/store control into
//   a req/ack transaction on the data-memory bus, stalls the pipeline until
//   the ack (or a timeout), and returns the extended load result.
//   Ports:
//     clk, reset          clock, asynchronous active-low reset
//     MemtoRegIn          load request
//     MemWriteIn          store request (wins over load)
//     MemOpIn             access size/sign (mips_mem_pkg MEMOP_*)
//     ALUResultIn         byte address
//     WriteDataIn         right-aligned store data
//     HaltIn              suppresses the access
//     MemReq/MemWe/MemAddr/MemBe/MemWdata   bus request side
//     MemAck/MemRdata     bus completion strobe and read data
//     Stall               freeze IF..EX/MEM
//     LoadDataOut         registered extended load data
//     LoadValid           one-cycle pulse with LoadDataOut
//     AlignErr            one-cycle pulse, misaligned or illegal op
//     BusErr              one-cycle pulse, ack timeout
// ---------------------------------------------------------------------------
module mem_access_unit
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemtoRegIn,
    input  logic              MemWriteIn,
    input  logic [2:0]        MemOpIn,
    input  logic [ADDR_W-1:0] ALUResultIn,
    input  logic [31:0]       WriteDataIn,
    input  logic              HaltIn,
    output logic              MemReq,
    output logic              MemWe,
    output logic [ADDR_W-3:0] MemAddr,
    output logic [3:0]        MemBe,
    output logic [31:0]       MemWdata,
    input  logic              MemAck,
    input  logic [31:0]       MemRdata,
    output logic              Stall,
    output logic [31:0]       LoadDataOut,
    output logic              LoadValid,
    output logic              AlignErr,
    output logic              BusErr
);

    localparam int              CW       = $clog2(TIMEOUT + 1);
    // Last REQ cycle index; the counter starts at 0 on entry to REQ.
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);

    mem_state_t        state_q;
    logic [2:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       data_q;
    logic              we_q;
    logic [CW-1:0]     cnt_q;

    logic              access;
    logic              legal;
    logic [3:0]        lane_be;
    logic [31:0]       lane_wdata;
    logic [31:0]       lane_ldata;

    assign access = (MemtoRegIn | MemWriteIn) & ~HaltIn;
    assign legal  = memop_legal(MemOpIn) & memop_aligned(MemOpIn, ALUResultIn[1:0]);

    mem_lane_align u_lane_align (
        .op_i    (op_q),
        .off_i   (addr_q[1:0]),
        .wdata_i (data_q),
        .rdata_i (MemRdata),
        .be_o    (lane_be),
        .wdata_o (lane_wdata),
        .ldata_o (lane_ldata)
    );

    // Bus outputs are decoded from registered state, so they drop the moment
    // reset clears state_q, and are zero whenever no request is in flight.
    assign MemReq   = (state_q == ST_REQ);
    assign MemWe    = MemReq & we_q;
    assign MemAddr  = MemReq ? addr_q[ADDR_W-1:2] : '0;
    assign MemBe    = MemReq ? lane_be : 4'b0000;
    assign MemWdata = MemReq ? lane_wdata : 32'h0;

    // Stall must rise in the same cycle the access is presented so EX/MEM
    // holds; gating with reset keeps it low while the unit is held in reset.
    assign Stall = reset & ((state_q == ST_REQ) |
                            ((state_q == ST_IDLE) & access & legal));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            op_q        <= 3'b000;
            addr_q      <= '0;
            data_q      <= 32'h0;
            we_q        <= 1'b0;
            cnt_q       <= '0;
            LoadDataOut <= 32'h0;
            LoadValid   <= 1'b0;
            AlignErr    <= 1'b0;
            BusErr      <= 1'b0;
        end else begin
            LoadValid <= 1'b0;
            AlignErr  <= 1'b0;
            BusErr    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (access) begin
                        if (legal) begin
                            op_q    <= MemOpIn;
                            addr_q  <= ALUResultIn;
                            data_q  <= WriteDataIn;
                            we_q    <= MemWriteIn;
                            cnt_q   <= '0;
                            state_q <= ST_REQ;
                        end else begin
                            AlignErr <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    if (MemAck) begin
                        if (!we_q) begin
                            LoadDataOut <= lane_ldata;
                        end
                        LoadValid <= ~we_q;
                        state_q   <= ST_DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        BusErr      <= 1'b1;
                        LoadDataOut <= 32'h0;
                        state_q     <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_DONE: begin
                    // EX/MEM advances this cycle; whatever it shows is ignored.
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs.
- Turns the latched load/store control (MemtoReg, MemWrite, MemOp, ALU address, store data) into a req/ack transaction on the data-memory bus.
- Stalls the pipeline until the memory acknowledges, then returns sign/zero-extended load data for the MEM/WB register.
- Flags misaligned accesses and bus timeouts.

Parameters:
- ADDR_W, 32: byte-address width; MemAddr carries bits [ADDR_W-1:2].
- TIMEOUT, 255: max cycles in REQ waiting for MemAck before BusErr; the counter width is clog2(TIMEOUT+1).

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- MemtoRegIn  in  1  load request from EX/MEM
- MemWriteIn  in  1  store request from EX/MEM
- MemOpIn  in  3  access size/sign: 000 byte signed, 001 half signed, 010 word, 011 byte unsigned, 100 half unsigned; others illegal
- ALUResultIn  in  ADDR_W  byte address
- WriteDataIn  in  32  store data, right-aligned
- HaltIn  in  1  halt marker; suppresses access
- MemReq  out  1  bus request, held until ack
- MemWe  out  1  1 = write
- MemAddr  out  ADDR_W-2  word address
- MemBe  out  4  byte enables, bit i = byte lane i, little-endian
- MemWdata  out  32  store data replicated into the selected lanes
- MemAck  in  1  one-cycle completion strobe
- MemRdata  in  32  read data, valid with MemAck
- Stall  out  1  freeze IF..EX/MEM while high
- LoadDataOut  out  32  extended load result, registered
- LoadValid  out  1  one-cycle pulse with LoadDataOut
- AlignErr  out  1  one-cycle pulse; misaligned or illegal op, no bus access
- BusErr  out  1  one-cycle pulse; timeout expired

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0; latched address, data, op and the timeout counter cleared. MemReq drops immediately, even mid-transaction; a later MemAck is ignored.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - Access = (MemtoRegIn | MemWriteIn) & !HaltIn.
  - If both load and store are set, treat it as a store.
  - Misaligned (half with addr[0]=1, word with addr[1:0]!=0) or illegal MemOp: pulse AlignErr next cycle, stay IDLE, Stall=0, no MemReq.
  - Legal access: latch op, address and data; go to REQ; Stall=1 combinationally in this cycle.
- REQ:
  - MemReq=1 with MemWe, MemAddr, MemBe and MemWdata stable; Stall=1; counter increments each cycle.
  - MemAck=1: capture MemRdata (loads) and go to DONE.
  - Counter reaches TIMEOUT with no ack: pulse BusErr, go to DONE with LoadDataOut=0.
- DONE:
  - Stall=0; LoadValid=1 for a load (held 0 on BusErr); LoadDataOut valid.
  - Inputs are ignored this cycle because EX/MEM is advancing.
  - Next state is IDLE.
- Minimum latency with ack in the first REQ cycle: 3 cycles from access presented to LoadValid (IDLE, REQ, DONE).
- Byte enables:
  - Byte: 0001 << addr[1:0].
  - Half: 0011 << addr[1:0].
  - Word: 1111.
- MemWdata lanes:
  - Byte: {4{data[7:0]}}.
  - Half: {2{data[15:0]}}.
  - Word: data.
- Load extraction: select the lane by addr[1:0], then sign-extend (000, 001) or zero-extend (011, 100) to 32 bits.
- MemAck outside REQ is ignored.
- LoadDataOut holds its value until the next load completes; it is not cleared in IDLE.

Decomposition:
- Shared package mips_mem_pkg:
  - MemOp encoding constants (MEMOP_LB, MEMOP_LH, MEMOP_LW, MEMOP_LBU, MEMOP_LHU).
  - FSM state encoding.
  - The same MemOp constants are reused by the decoder driving MemOpIn.
- One natural combinational sub-module, mem_lane_align:
  - Computes MemBe and MemWdata from (op, addr[1:0], data).
  - Extracts and extends the load result from (op, addr[1:0], MemRdata).
- The FSM and timeout counter stay in the top module.

Test Plan:
- LW, addr 0x100; MemAck on the 2nd REQ cycle, MemRdata 0xDEADBEEF -> MemAddr 0x40, MemBe 1111, Stall high 3 cycles, LoadValid pulse with LoadDataOut 0xDEADBEEF.
- LB at 0x103, MemRdata 0x80FFFFFF -> MemBe 1000, LoadDataOut 0xFFFFFF80. LBU at the same address -> 0x00000080.
- SH at 0x102, WriteData 0x0000ABCD -> MemWe 1, MemBe 1100, MemWdata 0xABCDABCD, LoadValid stays 0.
- LH at 0x101 -> AlignErr pulse, MemReq never asserted, Stall stays 0. MemOp 111 gives the same result.
- LW with no MemAck, TIMEOUT=4 -> MemReq held 4 cycles, BusErr pulse, LoadValid 0, return to IDLE.
- reset driven low in the 2nd REQ cycle, then MemAck -> MemReq and Stall fall immediately; the ack is ignored; after release the FSM is in IDLE with all outputs 0.
